// File: rtl/uart_chan_mux.sv
// uart_chan_mux: splits one UART byte stream into two channels tagged by bit 7.
//   bit7=1 -> protocol channel (pass-through strobe), bit7=0 -> bus-slave channel (FIFOs).
// Ports:
//   i_clk, i_reset_n                       clock, async active-low reset
//   i_rx_dat/i_rx_pulse                    byte + strobe from uart_rx
//   o_tx_dat/o_tx_start/i_tx_ready         byte + start strobe to uart_tx, tx idle
//   o_prot_rx_dat/o_prot_rx_pulse          protocol payload out
//   i_prot_tx_dat/i_prot_tx_pulse          protocol byte in (1-entry buffer)
//   o_prot_tx_ready                        protocol buffer empty
//   i_slave_addr/data/we/cs, o_slave_data  4-register slave port
//   o_slave_ack, o_int                     access ack, level interrupt
// Registers: 0 status (W1C bit4 overflow), 1 data (RX pop / TX push), 2 IE, 3 RX count.
// Optional macro UART_CHAN_THRESH_EN: addr 3 write sets an RX-count threshold that
// drives status bit5 and IE bit3.
module uart_chan_mux #(
  parameter int unsigned RX_DEPTH_LOG2 = 3,
  parameter int unsigned TX_DEPTH_LOG2 = 3,
  parameter int unsigned ARB_RR        = 0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [7:0] i_rx_dat,
  input  logic       i_rx_pulse,
  output logic [7:0] o_tx_dat,
  output logic       o_tx_start,
  input  logic       i_tx_ready,
  output logic [6:0] o_prot_rx_dat,
  output logic       o_prot_rx_pulse,
  input  logic [6:0] i_prot_tx_dat,
  input  logic       i_prot_tx_pulse,
  output logic       o_prot_tx_ready,
  input  logic [1:0] i_slave_addr,
  input  logic [7:0] i_slave_data,
  output logic [7:0] o_slave_data,
  input  logic       i_slave_we,
  input  logic       i_slave_cs,
  output logic       o_slave_ack,
  output logic       o_int
);

  localparam int unsigned RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int unsigned TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int unsigned RX_CW    = RX_DEPTH_LOG2 + 1;
  localparam int unsigned TX_CW    = TX_DEPTH_LOG2 + 1;

  typedef enum logic [0:0] {StIdle, StGap} tx_state_e;

  // RX FIFO
  logic [6:0]               rx_mem_q [RX_DEPTH];
  logic [RX_DEPTH_LOG2-1:0] rx_wr_q, rx_rd_q;
  logic [RX_CW-1:0]         rx_cnt_q;
  logic                     rx_empty, rx_full, rx_push_req, rx_push, rx_pop, ovf_set;

  // TX FIFO
  logic [6:0]               tx_mem_q [TX_DEPTH];
  logic [TX_DEPTH_LOG2-1:0] tx_wr_q, tx_rd_q;
  logic [TX_CW-1:0]         tx_cnt_q;
  logic                     tx_empty, tx_full, tx_push, tx_pop;

  // Protocol buffer, arbitration, FSM
  logic       prot_full_q;
  logic [6:0] prot_buf_q;
  logic       grant_slave, grant_prot;
  logic       rr_fav_slave_q;
  tx_state_e  tx_state_q;
  logic [7:0] tx_dat_q;
  logic       tx_start_q;

  // Slave port
  logic       slave_ack_q, slave_stb, slave_rd, slave_wr;
  logic [7:0] slave_data_q, rd_data;
  logic       overflow_q;
  logic [3:0] ie_q;
  logic       int_q;
  logic       thresh_hit;
  logic       prot_rx_pulse_q;
  logic [6:0] prot_rx_dat_q;
  logic       unused_slave_bit;

  assign unused_slave_bit = i_slave_data[7];

  assign slave_stb = i_slave_cs & ~slave_ack_q;
  assign slave_rd  = slave_stb & ~i_slave_we;
  assign slave_wr  = slave_stb & i_slave_we;

  assign rx_empty    = (rx_cnt_q == '0);
  assign rx_full     = (rx_cnt_q == RX_CW'(RX_DEPTH));
  assign rx_pop      = slave_rd & (i_slave_addr == 2'd1) & ~rx_empty;
  assign rx_push_req = i_rx_pulse & ~i_rx_dat[7];
  // A pop in the same cycle frees the slot, so push on full still succeeds.
  assign rx_push     = rx_push_req & (~rx_full | rx_pop);
  assign ovf_set     = rx_push_req & rx_full & ~rx_pop;

  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == TX_CW'(TX_DEPTH));
  assign tx_push  = slave_wr & (i_slave_addr == 2'd1) & ~tx_full;
  assign tx_pop   = grant_slave;

`ifdef UART_CHAN_THRESH_EN
  localparam bit ThreshEn = 1'b1;
  logic [7:0] thresh_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      thresh_q <= 8'd0;
    end else if (slave_wr && i_slave_addr == 2'd3) begin
      thresh_q <= i_slave_data;
    end
  end

  assign thresh_hit = (thresh_q != 8'd0) && (8'(rx_cnt_q) >= thresh_q);
`else
  localparam bit ThreshEn = 1'b0;
  assign thresh_hit = 1'b0;
`endif

  // FIFO storage is not reset; pointers and counts define validity.
  always_ff @(posedge i_clk) begin
    if (rx_push) rx_mem_q[rx_wr_q] <= i_rx_dat[6:0];
    if (tx_push) tx_mem_q[tx_wr_q] <= i_slave_data[6:0];
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_wr_q  <= '0;
      rx_rd_q  <= '0;
      rx_cnt_q <= '0;
    end else begin
      if (rx_push) rx_wr_q <= rx_wr_q + RX_DEPTH_LOG2'(1);
      if (rx_pop)  rx_rd_q <= rx_rd_q + RX_DEPTH_LOG2'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + RX_CW'(1);
        2'b01:   rx_cnt_q <= rx_cnt_q - RX_CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_wr_q  <= '0;
      tx_rd_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wr_q <= tx_wr_q + TX_DEPTH_LOG2'(1);
      if (tx_pop)  tx_rd_q <= tx_rd_q + TX_DEPTH_LOG2'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + TX_CW'(1);
        2'b01:   tx_cnt_q <= tx_cnt_q - TX_CW'(1);
        default: ;
      endcase
    end
  end

  // Protocol channel RX and 1-entry TX buffer
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prot_rx_pulse_q <= 1'b0;
      prot_rx_dat_q   <= 7'd0;
      prot_full_q     <= 1'b0;
      prot_buf_q      <= 7'd0;
    end else begin
      prot_rx_pulse_q <= i_rx_pulse & i_rx_dat[7];
      if (i_rx_pulse && i_rx_dat[7]) prot_rx_dat_q <= i_rx_dat[6:0];
      if (grant_prot) begin
        prot_full_q <= 1'b0;
      end else if (i_prot_tx_pulse && !prot_full_q) begin
        prot_full_q <= 1'b1;
        prot_buf_q  <= i_prot_tx_dat;
      end
    end
  end

  // Grant decision; only one source is ever granted per cycle.
  always_comb begin
    grant_slave = 1'b0;
    grant_prot  = 1'b0;
    if (tx_state_q == StIdle && i_tx_ready) begin
      if (ARB_RR != 0 && !tx_empty && prot_full_q) begin
        grant_slave = rr_fav_slave_q;
        grant_prot  = ~rr_fav_slave_q;
      end else begin
        grant_slave = ~tx_empty;
        grant_prot  = prot_full_q & tx_empty;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_state_q     <= StIdle;
      tx_start_q     <= 1'b0;
      tx_dat_q       <= 8'd0;
      rr_fav_slave_q <= 1'b1;
    end else begin
      unique case (tx_state_q)
        StIdle: begin
          if (grant_slave || grant_prot) begin
            tx_start_q     <= 1'b1;
            tx_dat_q       <= grant_slave ? {1'b0, tx_mem_q[tx_rd_q]} : {1'b1, prot_buf_q};
            rr_fav_slave_q <= grant_prot;
            tx_state_q     <= StGap;
          end else begin
            tx_start_q <= 1'b0;
          end
        end
        StGap: begin
          tx_start_q <= 1'b0;
          tx_state_q <= StIdle;
        end
        default: tx_state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    rd_data = 8'd0;
    unique case (i_slave_addr)
      2'd0: rd_data = {2'b00, thresh_hit, overflow_q, tx_full, tx_empty, rx_full, rx_empty};
      2'd1: rd_data = rx_empty ? 8'd0 : {1'b0, rx_mem_q[rx_rd_q]};
      2'd2: rd_data = {4'd0, ie_q};
      2'd3: rd_data = 8'(rx_cnt_q);
      default: rd_data = 8'd0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      slave_ack_q  <= 1'b0;
      slave_data_q <= 8'd0;
      overflow_q   <= 1'b0;
      ie_q         <= 4'd0;
      int_q        <= 1'b0;
    end else begin
      slave_ack_q <= slave_stb;
      if (slave_rd) slave_data_q <= rd_data;
      // A new overflow in the clearing cycle wins over the W1C.
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (slave_wr && i_slave_addr == 2'd0 && i_slave_data[4]) begin
        overflow_q <= 1'b0;
      end
      if (slave_wr && i_slave_addr == 2'd2) begin
        ie_q <= {i_slave_data[3] & ThreshEn, i_slave_data[2:0]};
      end
      int_q <= |(ie_q & {thresh_hit, overflow_q, tx_empty, ~rx_empty});
    end
  end

  assign o_tx_dat        = tx_dat_q;
  assign o_tx_start      = tx_start_q;
  assign o_prot_rx_dat   = prot_rx_dat_q;
  assign o_prot_rx_pulse = prot_rx_pulse_q;
  assign o_prot_tx_ready = ~prot_full_q;
  assign o_slave_data    = slave_data_q;
  assign o_slave_ack     = slave_ack_q;
  assign o_int           = int_q;

endmodule

// File: tb/tb_uart_chan_mux.sv
// Directed bench for uart_chan_mux. Two instances share all inputs:
//   a: RX depth 2, fixed priority;  b: RX depth 8, round-robin.
module tb_uart_chan_mux;

  logic       i_clk = 1'b0;
  logic       i_reset_n;
  logic [7:0] i_rx_dat;
  logic       i_rx_pulse;
  logic       i_tx_ready;
  logic [6:0] i_prot_tx_dat;
  logic       i_prot_tx_pulse;
  logic [1:0] i_slave_addr;
  logic [7:0] i_slave_data;
  logic       i_slave_we;
  logic       i_slave_cs;

  logic [7:0] a_tx_dat, b_tx_dat, a_slave_data, b_slave_data;
  logic       a_tx_start, b_tx_start, a_prot_rx_pulse, b_prot_rx_pulse;
  logic [6:0] a_prot_rx_dat, b_prot_rx_dat;
  logic       a_prot_tx_ready, b_prot_tx_ready, a_slave_ack, b_slave_ack, a_int, b_int;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  uart_chan_mux #(.RX_DEPTH_LOG2(1), .TX_DEPTH_LOG2(3), .ARB_RR(0)) u_dut_a (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_rx_dat(i_rx_dat), .i_rx_pulse(i_rx_pulse),
    .o_tx_dat(a_tx_dat), .o_tx_start(a_tx_start), .i_tx_ready(i_tx_ready),
    .o_prot_rx_dat(a_prot_rx_dat), .o_prot_rx_pulse(a_prot_rx_pulse),
    .i_prot_tx_dat(i_prot_tx_dat), .i_prot_tx_pulse(i_prot_tx_pulse),
    .o_prot_tx_ready(a_prot_tx_ready),
    .i_slave_addr(i_slave_addr), .i_slave_data(i_slave_data), .o_slave_data(a_slave_data),
    .i_slave_we(i_slave_we), .i_slave_cs(i_slave_cs), .o_slave_ack(a_slave_ack),
    .o_int(a_int)
  );

  uart_chan_mux #(.RX_DEPTH_LOG2(3), .TX_DEPTH_LOG2(3), .ARB_RR(1)) u_dut_b (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_rx_dat(i_rx_dat), .i_rx_pulse(i_rx_pulse),
    .o_tx_dat(b_tx_dat), .o_tx_start(b_tx_start), .i_tx_ready(i_tx_ready),
    .o_prot_rx_dat(b_prot_rx_dat), .o_prot_rx_pulse(b_prot_rx_pulse),
    .i_prot_tx_dat(i_prot_tx_dat), .i_prot_tx_pulse(i_prot_tx_pulse),
    .o_prot_tx_ready(b_prot_tx_ready),
    .i_slave_addr(i_slave_addr), .i_slave_data(i_slave_data), .o_slave_data(b_slave_data),
    .i_slave_we(i_slave_we), .i_slave_cs(i_slave_cs), .o_slave_ack(b_slave_ack),
    .o_int(b_int)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    i_rx_dat   = b;
    i_rx_pulse = 1'b1;
    step();
    i_rx_pulse = 1'b0;
  endtask

  task automatic slave_rd(input logic [1:0] addr, output logic [7:0] da, output logic [7:0] db);
    i_slave_addr = addr;
    i_slave_we   = 1'b0;
    i_slave_cs   = 1'b1;
    step();
    da = a_slave_data;
    db = b_slave_data;
    i_slave_cs = 1'b0;
    step();
  endtask

  task automatic slave_wr(input logic [1:0] addr, input logic [7:0] d);
    i_slave_addr = addr;
    i_slave_data = d;
    i_slave_we   = 1'b1;
    i_slave_cs   = 1'b1;
    step();
    i_slave_cs = 1'b0;
    i_slave_we = 1'b0;
    step();
  endtask

  task automatic prot_push(input logic [6:0] d);
    i_prot_tx_dat   = d;
    i_prot_tx_pulse = 1'b1;
    step();
    i_prot_tx_pulse = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] da, db;
    i_reset_n = 1'b1;
    #2 i_reset_n = 1'b0;
    #1;
    checks += 2;
    if ({a_tx_start, a_prot_rx_pulse, a_slave_ack, a_int, a_prot_tx_ready} !== 5'b00001) begin
      errors++; $display("FAIL reset_ctl_a: got %b want 00001",
                         {a_tx_start, a_prot_rx_pulse, a_slave_ack, a_int, a_prot_tx_ready});
    end
    if ({a_slave_data, a_tx_dat, a_prot_rx_dat} !== 23'd0) begin
      errors++; $display("FAIL reset_dat_a: got %h want 0", {a_slave_data, a_tx_dat, a_prot_rx_dat});
    end
    checks += 2;
    if ({b_tx_start, b_prot_rx_pulse, b_slave_ack, b_int, b_prot_tx_ready} !== 5'b00001) begin
      errors++; $display("FAIL reset_ctl_b: got %b want 00001",
                         {b_tx_start, b_prot_rx_pulse, b_slave_ack, b_int, b_prot_tx_ready});
    end
    if ({b_slave_data, b_tx_dat, b_prot_rx_dat} !== 23'd0) begin
      errors++; $display("FAIL reset_dat_b: got %h want 0", {b_slave_data, b_tx_dat, b_prot_rx_dat});
    end
    step();
    step();
    i_reset_n = 1'b1;
    step();
    slave_rd(2'd0, da, db);
    checks += 2;
    if (da !== 8'h05) begin errors++; $display("FAIL reset_status_a: got %h want 05", da); end
    if (db !== 8'h05) begin errors++; $display("FAIL reset_status_b: got %h want 05", db); end
  endtask

  task automatic test_rx_demux();
    logic [7:0] da, db;
    rx_byte(8'h85);
    checks += 2;
    if ({a_prot_rx_pulse, a_prot_rx_dat} !== {1'b1, 7'h05}) begin
      errors++; $display("FAIL prot_rx_a: got %b/%h want 1/05", a_prot_rx_pulse, a_prot_rx_dat);
    end
    if ({b_prot_rx_pulse, b_prot_rx_dat} !== {1'b1, 7'h05}) begin
      errors++; $display("FAIL prot_rx_b: got %b/%h want 1/05", b_prot_rx_pulse, b_prot_rx_dat);
    end
    step();
    checks++;
    if (a_prot_rx_pulse !== 1'b0) begin
      errors++; $display("FAIL prot_rx_width: got %b want 0", a_prot_rx_pulse);
    end
    rx_byte(8'h41);
    checks++;
    if (a_prot_rx_pulse !== 1'b0) begin
      errors++; $display("FAIL slave_byte_no_prot: got %b want 0", a_prot_rx_pulse);
    end
    slave_rd(2'd1, da, db);
    checks += 2;
    if (da !== 8'h41) begin errors++; $display("FAIL rx_read_a: got %h want 41", da); end
    if (db !== 8'h41) begin errors++; $display("FAIL rx_read_b: got %h want 41", db); end
    slave_rd(2'd0, da, db);
    checks += 2;
    if (da !== 8'h05) begin errors++; $display("FAIL rx_status_a: got %h want 05", da); end
    if (db !== 8'h05) begin errors++; $display("FAIL rx_status_b: got %h want 05", db); end
  endtask

  task automatic test_overflow();
    logic [7:0] da, db;
    logic [7:0] exp_a [3];
    logic [7:0] exp_b [3];
    exp_a = '{8'h01, 8'h02, 8'h00};
    exp_b = '{8'h01, 8'h02, 8'h03};
    rx_byte(8'h01);
    rx_byte(8'h02);
    rx_byte(8'h03);
    slave_rd(2'd0, da, db);
    checks += 2;
    if (da !== 8'h16) begin errors++; $display("FAIL ovf_status_a: got %h want 16", da); end
    if (db !== 8'h04) begin errors++; $display("FAIL ovf_status_b: got %h want 04", db); end
    for (int i = 0; i < 3; i++) begin
      slave_rd(2'd1, da, db);
      checks += 2;
      if (da !== exp_a[i]) begin
        errors++; $display("FAIL ovf_read_a[%0d]: got %h want %h", i, da, exp_a[i]);
      end
      if (db !== exp_b[i]) begin
        errors++; $display("FAIL ovf_read_b[%0d]: got %h want %h", i, db, exp_b[i]);
      end
    end
    slave_rd(2'd0, da, db);
    checks += 2;
    if (da !== 8'h15) begin errors++; $display("FAIL ovf_sticky_a: got %h want 15", da); end
    if (db !== 8'h05) begin errors++; $display("FAIL ovf_sticky_b: got %h want 05", db); end
    slave_wr(2'd2, 8'h04);
    checks += 2;
    if (a_int !== 1'b1) begin errors++; $display("FAIL ovf_int_a: got %b want 1", a_int); end
    if (b_int !== 1'b0) begin errors++; $display("FAIL ovf_int_b: got %b want 0", b_int); end
    slave_wr(2'd0, 8'h10);
    checks++;
    if (a_int !== 1'b0) begin errors++; $display("FAIL ovf_clr_int: got %b want 0", a_int); end
    slave_rd(2'd0, da, db);
    checks++;
    if (da !== 8'h05) begin errors++; $display("FAIL ovf_clr_status: got %h want 05", da); end
    slave_wr(2'd2, 8'h00);
  endtask

  task automatic test_tx_priority();
    logic [7:0] da, db;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int ca[$];
    int cb[$];
    logic [7:0] exp_a [3];
    logic [7:0] exp_b [3];
    exp_a = '{8'h11, 8'h22, 8'hB3};
    exp_b = '{8'h11, 8'hB3, 8'h22};
    i_tx_ready = 1'b0;
    slave_wr(2'd1, 8'h11);
    slave_wr(2'd1, 8'h22);
    prot_push(7'h33);
    checks++;
    if (a_prot_tx_ready !== 1'b0) begin
      errors++; $display("FAIL prot_ready_drop: got %b want 0", a_prot_tx_ready);
    end
    prot_push(7'h44);  // buffer full: must be ignored
    i_tx_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      step();
      if (a_tx_start) begin qa.push_back(a_tx_dat); ca.push_back(c); end
      if (b_tx_start) begin qb.push_back(b_tx_dat); cb.push_back(c); end
    end
    i_tx_ready = 1'b0;
    checks += 2;
    if (qa.size() != 3) begin errors++; $display("FAIL tx_count_a: got %0d want 3", qa.size()); end
    if (qb.size() != 3) begin errors++; $display("FAIL tx_count_b: got %0d want 3", qb.size()); end
    if (qa.size() == 3 && qb.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        checks += 2;
        if (qa[i] !== exp_a[i]) begin
          errors++; $display("FAIL tx_order_a[%0d]: got %h want %h", i, qa[i], exp_a[i]);
        end
        if (qb[i] !== exp_b[i]) begin
          errors++; $display("FAIL tx_order_b[%0d]: got %h want %h", i, qb[i], exp_b[i]);
        end
        if (i > 0) begin
          checks += 2;
          if (ca[i] - ca[i-1] != 2) begin
            errors++; $display("FAIL tx_gap_a[%0d]: got %0d want 2", i, ca[i] - ca[i-1]);
          end
          if (cb[i] - cb[i-1] != 2) begin
            errors++; $display("FAIL tx_gap_b[%0d]: got %0d want 2", i, cb[i] - cb[i-1]);
          end
        end
      end
    end
    checks += 2;
    if (b_prot_tx_ready !== 1'b1) begin
      errors++; $display("FAIL prot_ready_back: got %b want 1", b_prot_tx_ready);
    end
    slave_rd(2'd0, da, db);
    if (da !== 8'h05) begin errors++; $display("FAIL tx_drained_status: got %h want 05", da); end
  endtask

  task automatic test_slave_handshake();
    logic [7:0] da, db;
    logic       exp_ack [4];
    exp_ack = '{1'b1, 1'b0, 1'b1, 1'b0};
    rx_byte(8'h21);
    rx_byte(8'h32);
    i_slave_addr = 2'd1;
    i_slave_we   = 1'b0;
    i_slave_cs   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks += 2;
      if (a_slave_ack !== exp_ack[k]) begin
        errors++; $display("FAIL hs_ack_a[%0d]: got %b want %b", k, a_slave_ack, exp_ack[k]);
      end
      if (b_slave_ack !== exp_ack[k]) begin
        errors++; $display("FAIL hs_ack_b[%0d]: got %b want %b", k, b_slave_ack, exp_ack[k]);
      end
      if (k == 0) begin
        checks++;
        if (a_slave_data !== 8'h21) begin
          errors++; $display("FAIL hs_data0: got %h want 21", a_slave_data);
        end
      end
      if (k == 2) begin
        checks++;
        if (b_slave_data !== 8'h32) begin
          errors++; $display("FAIL hs_data1: got %h want 32", b_slave_data);
        end
      end
    end
    i_slave_cs = 1'b0;
    step();
    slave_rd(2'd3, da, db);
    checks += 2;
    if (da !== 8'h00) begin errors++; $display("FAIL hs_count_a: got %h want 00", da); end
    if (db !== 8'h00) begin errors++; $display("FAIL hs_count_b: got %h want 00", db); end
  endtask

`ifdef UART_CHAN_THRESH_EN
  task automatic test_threshold();
    logic [7:0] da, db;
    slave_wr(2'd3, 8'h03);
    slave_wr(2'd2, 8'h08);
    slave_rd(2'd2, da, db);
    checks++;
    if (db !== 8'h08) begin errors++; $display("FAIL th_ie: got %h want 08", db); end
    rx_byte(8'h01);
    rx_byte(8'h02);
    rx_byte(8'h03);
    checks++;
    if (b_int !== 1'b0) begin errors++; $display("FAIL th_int_early: got %b want 0", b_int); end
    step();
    checks += 2;
    if (b_int !== 1'b1) begin errors++; $display("FAIL th_int_rise: got %b want 1", b_int); end
    if (a_int !== 1'b0) begin errors++; $display("FAIL th_int_a: got %b want 0", a_int); end
    slave_rd(2'd0, da, db);
    checks++;
    if (db !== 8'h24) begin errors++; $display("FAIL th_status: got %h want 24", db); end
    slave_rd(2'd1, da, db);
    checks++;
    if (b_int !== 1'b0) begin errors++; $display("FAIL th_int_drop: got %b want 0", b_int); end
    slave_rd(2'd1, da, db);
    slave_rd(2'd1, da, db);
    slave_wr(2'd0, 8'h10);
    slave_wr(2'd2, 8'h00);
    slave_wr(2'd3, 8'h00);
  endtask
`else
  task automatic test_threshold();
    logic [7:0] da, db;
    slave_wr(2'd2, 8'h0F);
    checks++;
    if (a_int !== 1'b1) begin errors++; $display("FAIL nth_int_txempty: got %b want 1", a_int); end
    slave_rd(2'd2, da, db);
    checks += 2;
    if (da !== 8'h07) begin errors++; $display("FAIL nth_ie_a: got %h want 07", da); end
    if (db !== 8'h07) begin errors++; $display("FAIL nth_ie_b: got %h want 07", db); end
    slave_wr(2'd3, 8'h01);
    slave_rd(2'd0, da, db);
    checks++;
    if (db !== 8'h05) begin errors++; $display("FAIL nth_status: got %h want 05", db); end
    slave_wr(2'd2, 8'h00);
  endtask
`endif

  task automatic test_reset_mid();
    logic [7:0] da, db;
    int starts;
    i_tx_ready = 1'b0;
    slave_wr(2'd1, 8'h55);
    slave_wr(2'd1, 8'h66);
    prot_push(7'h7F);
    i_tx_ready = 1'b1;
    step();
    checks++;
    if ({a_tx_start, a_tx_dat} !== {1'b1, 8'h55}) begin
      errors++; $display("FAIL mid_start: got %b/%h want 1/55", a_tx_start, a_tx_dat);
    end
    #2 i_reset_n = 1'b0;
    #1;
    checks += 2;
    if ({a_tx_start, a_tx_dat, a_prot_tx_ready, a_int} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mid_reset_a: got %b/%h/%b/%b want 0/00/1/0",
                         a_tx_start, a_tx_dat, a_prot_tx_ready, a_int);
    end
    if ({b_tx_start, b_tx_dat, b_prot_tx_ready, b_int} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL mid_reset_b: got %b/%h/%b/%b want 0/00/1/0",
                         b_tx_start, b_tx_dat, b_prot_tx_ready, b_int);
    end
    step();
    i_reset_n = 1'b1;
    starts = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (a_tx_start || b_tx_start) starts++;
    end
    checks++;
    if (starts != 0) begin errors++; $display("FAIL mid_discard: got %0d starts want 0", starts); end
    slave_rd(2'd0, da, db);
    checks += 2;
    if (da !== 8'h05) begin errors++; $display("FAIL mid_status_a: got %h want 05", da); end
    if (db !== 8'h05) begin errors++; $display("FAIL mid_status_b: got %h want 05", db); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rx_dat        = 8'd0;
    i_rx_pulse      = 1'b0;
    i_tx_ready      = 1'b0;
    i_prot_tx_dat   = 7'd0;
    i_prot_tx_pulse = 1'b0;
    i_slave_addr    = 2'd0;
    i_slave_data    = 8'd0;
    i_slave_we      = 1'b0;
    i_slave_cs      = 1'b0;
    test_reset();
    test_rx_demux();
    test_overflow();
    test_tx_priority();
    test_slave_handshake();
    test_threshold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
